// File: rtl/bip2_ctrl_fsm_if.sv
// Control-unit bus of the BIP-2 core: ROM opcode, run and status flags in,
// every datapath strobe out. The slave side is the control FSM.
interface bip2_ctrl_fsm_if #(
  parameter int OPW    = 5,
  parameter int SELA   = 2,
  parameter int ALUOPW = 3
);
  logic              run_i;
  logic [OPW-1:0]    opcode_i;
  logic              z_flag_i;
  logic              n_flag_i;
  logic              ir_wr_o;
  logic              pc_wr_o;
  logic              pc_sel_o;
  logic [SELA-1:0]   sela_o;
  logic              selb_o;
  logic [ALUOPW-1:0] op_ula_o;
  logic              wr_acc_o;
  logic              wr_status_o;
  logic              wr_ram_o;
  logic              halted_o;
  logic              illegal_o;
  logic [2:0]        state_o;

  modport master (
    output run_i, opcode_i, z_flag_i, n_flag_i,
    input  ir_wr_o, pc_wr_o, pc_sel_o, sela_o, selb_o, op_ula_o,
           wr_acc_o, wr_status_o, wr_ram_o, halted_o, illegal_o, state_o
  );

  modport slave (
    input  run_i, opcode_i, z_flag_i, n_flag_i,
    output ir_wr_o, pc_wr_o, pc_sel_o, sela_o, selb_o, op_ula_o,
           wr_acc_o, wr_status_o, wr_ram_o, halted_o, illegal_o, state_o
  );
endinterface

// File: rtl/bip2_ctrl_fsm.sv
// BIP-2 multicycle control unit: FETCH/DECODE/EXEC/WB sequencing with Moore
// strobes decoded from the state and the opcode latched at FETCH.
module bip2_ctrl_fsm #(
  parameter int OPW    = 5,
  parameter int SELA   = 2,
  parameter int ALUOPW = 3
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  bip2_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
  localparam logic [OPW-1:0] OP_STO  = OPW'(1);
  localparam logic [OPW-1:0] OP_LD   = OPW'(2);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(3);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(7);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(8);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(9);
  localparam logic [OPW-1:0] OP_BGT  = OPW'(10);
  localparam logic [OPW-1:0] OP_BGE  = OPW'(11);
  localparam logic [OPW-1:0] OP_BLT  = OPW'(12);
  localparam logic [OPW-1:0] OP_BLE  = OPW'(13);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(14);
  localparam logic [OPW-1:0] OP_FIRST_ILLEGAL = OPW'(15);

  state_t            r_state;
  state_t            w_next_state;
  logic [OPW-1:0]    r_op_q;
  logic              w_ir_load;
  logic [SELA-1:0]   w_sela;
  logic              w_selb;
  logic [ALUOPW-1:0] w_op_ula;
  logic              w_acc_op;
  logic              w_status_op;
  logic              w_branch_taken;
  logic              w_illegal_op;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_RST;
      r_op_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      r_state <= w_next_state;
      if (w_ir_load) r_op_q <= bus.opcode_i;
    end
  end

  // Opcode decode; branch conditions read the live flags because they only matter in WB.
  always_comb begin
    w_sela         = '0;
    w_selb         = 1'b0;
    w_op_ula       = '0;
    w_acc_op       = 1'b0;
    w_status_op    = 1'b0;
    w_branch_taken = 1'b0;
    w_illegal_op   = (r_op_q >= OP_FIRST_ILLEGAL);
    case (r_op_q)
      OP_LD:   w_acc_op = 1'b1;
      OP_LDI:  begin w_acc_op = 1'b1; w_sela = SELA'(1); end
      OP_ADD:  begin w_acc_op = 1'b1; w_status_op = 1'b1; w_sela = SELA'(2); end
      OP_ADDI: begin w_acc_op = 1'b1; w_status_op = 1'b1; w_sela = SELA'(2); w_selb = 1'b1; end
      OP_SUB:  begin
        w_acc_op = 1'b1; w_status_op = 1'b1; w_sela = SELA'(2); w_op_ula = ALUOPW'(1);
      end
      OP_SUBI: begin
        w_acc_op = 1'b1; w_status_op = 1'b1; w_sela = SELA'(2); w_op_ula = ALUOPW'(1);
        w_selb   = 1'b1;
      end
      OP_BEQ:  w_branch_taken = bus.z_flag_i;
      OP_BNE:  w_branch_taken = !bus.z_flag_i;
      OP_BGT:  w_branch_taken = !bus.z_flag_i && !bus.n_flag_i;
      OP_BGE:  w_branch_taken = !bus.n_flag_i;
      OP_BLT:  w_branch_taken = bus.n_flag_i;
      OP_BLE:  w_branch_taken = bus.n_flag_i || bus.z_flag_i;
      OP_JMP:  w_branch_taken = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    w_next_state    = r_state;
    w_ir_load       = 1'b0;
    bus.ir_wr_o     = 1'b0;
    bus.pc_wr_o     = 1'b0;
    bus.pc_sel_o    = 1'b0;
    bus.sela_o      = '0;
    bus.selb_o      = 1'b0;
    bus.op_ula_o    = '0;
    bus.wr_acc_o    = 1'b0;
    bus.wr_status_o = 1'b0;
    bus.wr_ram_o    = 1'b0;
    bus.halted_o    = 1'b0;
    bus.illegal_o   = 1'b0;
    // Datapath selects are held stable from DECODE through WB.
    if (r_state == S_DECODE || r_state == S_EXEC || r_state == S_WB) begin
      bus.sela_o   = w_sela;
      bus.selb_o   = w_selb;
      bus.op_ula_o = w_op_ula;
    end
    case (r_state)
      S_RST:   w_next_state = S_FETCH;
      S_FETCH: begin
        if (bus.run_i) begin
          w_ir_load    = 1'b1;
          bus.ir_wr_o  = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (r_op_q == OP_HLT) begin
          w_next_state = S_HALT;
        end else begin
          bus.illegal_o = w_illegal_op;
          w_next_state  = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.wr_ram_o = (r_op_q == OP_STO);
        w_next_state = S_WB;
      end
      S_WB: begin
        bus.pc_wr_o     = 1'b1;
        bus.wr_acc_o    = w_acc_op;
        bus.wr_status_o = w_status_op;
        bus.pc_sel_o    = w_branch_taken;
        w_next_state    = S_FETCH;
      end
      S_HALT:  bus.halted_o = 1'b1;
      default: w_next_state = S_RST;
    endcase
  end

  assign bus.state_o = r_state;

endmodule
